// File: rtl/lfsr_checker.sv
// lfsr_checker: locks onto an 8-bit Fibonacci LFSR stream and counts mispredicted words while locked.
// Define LFSR_CHK_BITERR_EN to count differing bits instead of words and expose bit_errs.
module lfsr_checker #(
  parameter logic [7:0] TAPS       = 8'hB8,
  parameter int         LOCK_COUNT = 4,
  parameter int         LOSS_COUNT = 3,
  parameter int         ERR_W      = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [7:0]       value,
  input  logic             clear_err,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
`ifdef LFSR_CHK_BITERR_EN
  output logic [3:0]       bit_errs,
`endif
  output logic             zero_seen
);
  typedef enum logic [1:0] {SEED, TRAIN, LOCKED} state_t;
  localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);
  state_t state, state_nx;
  logic [7:0] pred, pred_nx;
  logic [3:0] cnt, cnt_nx, miss, miss_nx, inc;
  logic locked_nx, miss_ev, hit;
  logic [ERR_W-1:0] base, count_nx;
  logic [ERR_W:0] sum;
  function automatic logic [7:0] nxt(input logic [7:0] p);
    return {p[6:0], ^(p & TAPS)};
  endfunction
  function automatic logic [3:0] pop(input logic [7:0] x);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b0, x[i]};
    return c;
  endfunction
  always_comb begin
    state_nx  = state;
    pred_nx   = pred;
    cnt_nx    = cnt;
    miss_nx   = miss;
    locked_nx = locked;
    miss_ev   = 1'b0;
    hit       = value == pred;
    if (enable)
      case (state)
        SEED:
          if (value != 8'h00) begin
            pred_nx  = nxt(value);
            cnt_nx   = '0;
            state_nx = TRAIN;
          end
        TRAIN: begin
          pred_nx = nxt(value);
          cnt_nx  = hit ? cnt + 4'd1 : '0;
          if (hit && cnt + 4'd1 == LOCK_N) begin
            state_nx  = LOCKED;
            locked_nx = 1'b1;
          end
        end
        LOCKED: begin
          // free-run the predictor so a corrupted word cannot poison it
          pred_nx = nxt(pred);
          miss_ev = !hit;
          miss_nx = hit ? '0 : miss + 4'd1;
          if (!hit && miss + 4'd1 == LOSS_N) begin
            state_nx  = SEED;
            locked_nx = 1'b0;
            miss_nx   = '0;
          end
        end
        default: state_nx = SEED;
      endcase
  end
`ifdef LFSR_CHK_BITERR_EN
  assign inc = pop(value ^ pred);
`else
  assign inc = 4'd1;
`endif
  always_comb begin
    base     = clear_err ? '0 : err_count;
    sum      = {1'b0, base} + {{(ERR_W-3){1'b0}}, inc};
    count_nx = miss_ev ? (sum[ERR_W] ? '1 : sum[ERR_W-1:0]) : base;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state     <= SEED;
      pred      <= 8'h00;
      cnt       <= '0;
      miss      <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_count <= '0;
      zero_seen <= 1'b0;
`ifdef LFSR_CHK_BITERR_EN
      bit_errs  <= '0;
`endif
    end else begin
      state     <= state_nx;
      pred      <= pred_nx;
      cnt       <= cnt_nx;
      miss      <= miss_nx;
      locked    <= locked_nx;
      err       <= miss_ev;
      err_count <= count_nx;
      zero_seen <= zero_seen | (enable && value == 8'h00);
`ifdef LFSR_CHK_BITERR_EN
      if (miss_ev) bit_errs <= inc;
`endif
    end
endmodule

// File: tb/tb_lfsr_checker.sv
// tb_lfsr_checker: directed stimulus for lfsr_checker with expected values tracked in the bench.
module tb_lfsr_checker;
  logic clk = 0, reset_n = 0, enable = 0, clear_err = 0;
  logic [7:0] value = 0;
  logic locked, err, zero_seen;
  logic [15:0] err_count;
`ifdef LFSR_CHK_BITERR_EN
  logic [3:0] bit_errs;
`endif
  int checks = 0, errors = 0, ec = 0, pulses = 0;
  logic [7:0] s;

  always #5 clk = ~clk;

  lfsr_checker dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .value(value), .clear_err(clear_err),
    .locked(locked), .err(err), .err_count(err_count),
`ifdef LFSR_CHK_BITERR_EN
    .bit_errs(bit_errs),
`endif
    .zero_seen(zero_seen)
  );

  function automatic logic [7:0] nxt(input logic [7:0] p);
    return {p[6:0], p[7] ^ p[5] ^ p[4] ^ p[3]};
  endfunction

  function automatic int inc(input logic [7:0] d);
`ifdef LFSR_CHK_BITERR_EN
    return $countones(d);
`else
    return 1;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] v);
    value = v;
    enable = 1;
    @(posedge clk);
    #1;
    enable = 0;
    clear_err = 0;
  endtask

  task automatic good;
    send(s);
    s = nxt(s);
  endtask

  task automatic bad(input logic [7:0] m);
    send(s ^ m);
    ec += inc(m);
    s = nxt(s);
  endtask

  initial begin
    #12;
    check("rst_locked", locked, 0);
    check("rst_err", err, 0);
    check("rst_count", err_count, 0);
    check("rst_zero", zero_seen, 0);
    @(negedge clk) reset_n = 1;

    s = 8'h01;
    repeat (4) good;
    check("prelock", locked, 0);
    good;
    check("lock_5th", locked, 1);
    check("lock_err", err, 0);

    pulses = 0;
    repeat (300) begin good; pulses += int'(err); end
    check("clean_pulses", pulses, 0);
    check("clean_count", err_count, 0);
    check("clean_locked", locked, 1);

    bad(8'h01);
    check("single_err", err, 1);
    check("single_count", err_count, ec);
    check("single_locked", locked, 1);
    good;
    check("single_next_err", err, 0);
    check("single_next_count", err_count, ec);

    pulses = 0;
    repeat (10) begin @(posedge clk); #1; pulses += int'(err); end
    check("gap_pulses", pulses, 0);
    check("gap_locked", locked, 1);
    check("gap_count", err_count, ec);
    good;
    check("gap_resume_err", err, 0);

    clear_err = 1;
    ec = 0;
    bad(8'hFF);
    check("clear_err_pulse", err, 1);
    check("clear_count", err_count, ec);
`ifdef LFSR_CHK_BITERR_EN
    check("bit_errs", bit_errs, 8);
`endif
    good;
    check("clear_next_err", err, 0);

    bad(8'h01);
    check("loss1_err", err, 1);
    check("loss1_locked", locked, 1);
    bad(8'h01);
    check("loss2_locked", locked, 1);
    bad(8'h01);
    check("loss3_err", err, 1);
    check("loss3_locked", locked, 0);
    check("loss_count", err_count, ec);

    pulses = 0;
    repeat (4) begin good; pulses += int'(err); end
    check("relock_pre", locked, 0);
    good;
    check("relock", locked, 1);
    check("relock_pulses", pulses + int'(err), 0);
    check("relock_count", err_count, ec);

    send(8'h00);
    ec += inc(s);
    s = nxt(s);
    check("zero_seen", zero_seen, 1);
    check("zero_err", err, 1);
    check("zero_count", err_count, ec);
    good;
    good;
    check("zero_sticky", zero_seen, 1);

    reset_n = 0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_count", err_count, 0);
    check("arst_zero", zero_seen, 0);
    @(negedge clk) reset_n = 1;

    send(8'h00);
    repeat (4) good;
    check("seed_zero_prelock", locked, 0);
    good;
    check("seed_zero_lock", locked, 1);
    check("seed_zero_seen", zero_seen, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
